multi_dynamic_delay: RTL

- Parametrised multi-channel successor to the per-bit dynamic delay line.
- CHANNELS independent WIDTH-bit sample streams share one circular buffer of LENGTH entries and one write pointer.
- Each channel has its own runtime-programmable delay register, a per-channel output-valid flag and a synchronous flush.
- Used as a register-heavy plus mux-heavy benchmark load and as a general programmable delay/alignment block.

---
 rtl/multi_dynamic_delay.sv | 104 ++++++++++
 1 files changed

// File: rtl/multi_dynamic_delay.sv
// Multi-channel programmable delay line sharing one circular buffer.
// Each channel taps the buffer at its own runtime delay.
module multi_dynamic_delay #(
  parameter int CHANNELS    = 16,
  parameter int WIDTH       = 16,
  parameter int LENGTH      = 1024,
  parameter int SEL_W       = $clog2(LENGTH),
  parameter int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  parameter int DEFAULT_SEL = 0
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      ena,
  input  logic                      flush,
  input  logic [CHANNELS*WIDTH-1:0] in,
  input  logic                      sel_wr,
  input  logic [CH_W-1:0]           sel_ch,
  input  logic [SEL_W-1:0]          sel_data,
  output logic [CHANNELS*WIDTH-1:0] out,
  output logic [CHANNELS-1:0]       out_valid
);

  localparam int DW = CHANNELS * WIDTH;
  localparam logic [SEL_W-1:0] MAXSEL = SEL_W'(LENGTH - 1);
  localparam logic [SEL_W-1:0] DEFSEL =
    (DEFAULT_SEL > LENGTH - 1) ? MAXSEL : SEL_W'(DEFAULT_SEL);
  localparam logic [SEL_W:0] LEN = (SEL_W + 1)'(LENGTH);

  logic [DW-1:0]       mem [LENGTH];
  logic [SEL_W-1:0]    wptr;
  logic [SEL_W:0]      fill;
  logic [SEL_W-1:0]    sel [CHANNELS];
  logic [SEL_W-1:0]    raddr [CHANNELS];
  logic [SEL_W-1:0]    sel_sat;
  logic [DW-1:0]       out_q;
  logic [DW-1:0]       out_nxt;
  logic [CHANNELS-1:0] vld_q;
  logic [CHANNELS-1:0] vld_nxt;

  assign out       = out_q;
  assign out_valid = vld_q;

  // clamp incoming delay to the deepest available tap
  always_comb begin
    sel_sat = (sel_data > MAXSEL) ? MAXSEL : sel_data;
  end

  // per-channel tap address, validity and next output sample
  always_comb begin
    logic [SEL_W:0] diff;
    diff    = '0;
    out_nxt = '0;
    vld_nxt = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      diff = {1'b0, wptr} - {1'b0, sel[c]};
      if (diff[SEL_W]) diff = diff + LEN;
      raddr[c] = diff[SEL_W-1:0];
      vld_nxt[c] = (fill >= {1'b0, sel[c]});
      if (!vld_nxt[c])
        out_nxt[c*WIDTH +: WIDTH] = '0;
      else if (sel[c] == '0)
        out_nxt[c*WIDTH +: WIDTH] = in[c*WIDTH +: WIDTH];
      else
        out_nxt[c*WIDTH +: WIDTH] =
          mem[raddr[c]][c*WIDTH +: WIDTH];
    end
  end

  // sample storage; contents deliberately survive reset and flush
  always_ff @(posedge clk) begin
    if (ena && !flush) mem[wptr] <= in;
  end

  // write pointer, fill count and registered outputs
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wptr  <= '0;
      fill  <= '0;
      out_q <= '0;
      vld_q <= '0;
    end else if (flush) begin
      wptr  <= '0;
      fill  <= '0;
      out_q <= '0;
      vld_q <= '0;
    end else if (ena) begin
      wptr  <= (wptr == MAXSEL) ? '0 : wptr + 1'b1;
      if (fill != LEN) fill <= fill + 1'b1;
      out_q <= out_nxt;
      vld_q <= vld_nxt;
    end
  end

  // per-channel delay registers; out-of-range channels ignored
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int c = 0; c < CHANNELS; c++) sel[c] <= DEFSEL;
    end else if (sel_wr) begin
      for (int c = 0; c < CHANNELS; c++)
        if (sel_ch == CH_W'(c)) sel[c] <= sel_sat;
    end
  end

endmodule
